// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial ripple-borrow subtractor: Diff = A - B - Bin, one full-subtractor
//   cell, one bit per clock, LSB first. A start/busy/done handshake launches an
//   operation and marks its result.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   launch request, sampled only in IDLE
//   A      in   minuend   [WIDTH-1:0], sampled on the accepting edge
//   B      in   subtrahend [WIDTH-1:0], sampled on the accepting edge
//   Bin    in   borrow-in, sampled on the accepting edge
//   Diff   out  registered (A - B - Bin) mod 2^WIDTH, holds last result
//   Bout   out  registered borrow-out (A < B + Bin, unsigned)
//   busy   out  high while bits are being processed (WIDTH cycles)
//   done   out  one-cycle pulse marking a new Diff/Bout
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;
  logic             last;
  logic [WIDTH-1:0] d_shift;
  logic             d_unused;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    a_bit   = a_sr[0];
    b_bit   = b_sr[0];
    d_bit   = a_bit ^ b_bit ^ br;
    br_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    d_shift = {d_bit, d_sr[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
  end

  // d_sr[0] is shifted out on the final edge; the completed word is taken
  // from d_shift, so that bit is never observed.
  assign d_unused = d_sr[0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand/result shift registers, borrow flop, bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            br   <= Bin;
            cnt  <= '0;
            d_sr <= '0;
          end
        end
        SHIFT: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          d_sr <= d_shift;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            Diff <= d_shift;
            Bout <= br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH=4 instance for directed tests
  logic       rst4, start4, bin4;
  logic [3:0] a4, b4, diff4;
  logic       bout4, busy4, done4;

  // WIDTH=8 instance for random regression
  logic       rst8, start8, bin8;
  logic [7:0] a8, b8, diff8;
  logic       bout8, busy8, done8;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4), .start(start4), .A(a4), .B(b4), .Bin(bin4),
    .Diff(diff4), .Bout(bout4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .Diff(diff8), .Bout(bout8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      input logic [3:0] d, input logic bo, input string tag);
    int lat;
    int busy_n;
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    step();
    start4 = 1'b0;
    lat = 0; busy_n = 0;
    while (!done4 && lat < 20) begin
      if (busy4) busy_n++;
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " busy_cycles"}, busy_n, 4);
    chk({tag, " busy_at_done"}, {31'b0, busy4}, 0);
    chk({tag, " diff"}, {28'b0, diff4}, {28'b0, d});
    chk({tag, " bout"}, {31'b0, bout4}, {31'b0, bo});
    step();
    chk({tag, " done_one_cycle"}, {31'b0, done4}, 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] ref_r;
    int lat;
    ref_r = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 0;
    while (!done8 && lat < 30) begin
      step();
      lat++;
    end
    chk("w8 latency", lat, 8);
    chk("w8 result", {23'b0, bout8, diff8}, {23'b0, ref_r});
    step();
  endtask

  initial begin
    int nd;
    tbl[0] = '{4'b1000, 4'b1101, 1'b1, 4'b1010, 1'b1};
    tbl[1] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1};
    tbl[2] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0};
    tbl[3] = '{4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0};
    tbl[4] = '{4'b1101, 4'b0111, 1'b0, 4'b0110, 1'b0};
    tbl[5] = '{4'b1010, 4'b1100, 1'b0, 4'b1110, 1'b1};
    tbl[6] = '{4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0};

    rst4 = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    rst8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    step(); step();
    chk("reset4 outputs", {25'b0, diff4, bout4, busy4, done4}, 0);
    chk("reset8 outputs", {21'b0, diff8, bout8, busy8, done8}, 0);
    rst4 = 1'b1; rst8 = 1'b1;
    step();

    // Table-driven directed vectors
    for (int i = 0; i < 7; i++) begin
      run4(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, $sformatf("vec%0d", i));
    end

    // Async reset mid-operation: Diff is nonzero (0010) before this
    a4 = 4'b1010; b4 = 4'b0101; bin4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step(); step();
    #2 rst4 = 1'b0;
    #1 chk("async reset outputs", {25'b0, diff4, bout4, busy4, done4}, 0);
    step(); step();
    rst4 = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done4) nd++;
      step();
    end
    chk("no done after abort", nd, 0);
    chk("diff stays cleared", {28'b0, diff4}, 0);
    run4(4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, "after_reset");

    // Ignored start and operand stability
    a4 = 4'b1101; b4 = 4'b0111; bin4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    start4 = 1'b1; a4 = 4'b0000; b4 = 4'b1111; bin4 = 1'b1;
    step();
    start4 = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) nd++;
      step();
    end
    chk("ignored start done count", nd, 1);
    chk("ignored start diff", {28'b0, diff4}, 32'h6);
    chk("ignored start bout", {31'b0, bout4}, 0);

    // Back-to-back with start held high
    a4 = 4'b1010; b4 = 4'b1100; bin4 = 1'b0; start4 = 1'b1;
    step();
    a4 = 4'b0011; b4 = 4'b0001;
    nd = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (done4) nd++;
      if (k == 4) begin
        chk("b2b first done", {31'b0, done4}, 1);
        chk("b2b first result", {27'b0, bout4, diff4}, {27'b0, 5'b11110});
      end
      if (k == 7) start4 = 1'b0;
      if (k == 9) chk("b2b diff holds", {28'b0, diff4}, 32'he);
      if (k == 10) begin
        chk("b2b second done", {31'b0, done4}, 1);
        chk("b2b second result", {27'b0, bout4, diff4}, {27'b0, 5'b00010});
      end
    end
    chk("b2b done count", nd, 2);
    step(); step(); step();

    // WIDTH=8 random regression
    run8(8'h00, 8'hFF, 1'b1);
    run8(8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor. It computes Diff = A - B - Bin using one full-subtractor cell, processing one bit per clock, LSB first.
- It is the inverse-operation companion to the team's combinational ripple-carry adder. It trades latency for area in datapaths where subtraction is infrequent.
- A start/busy/done handshake lets a controlling FSM launch an operation and collect the result.

Parameters:
- WIDTH, 4, operand and result width in bits. Legal range is 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- Bin  input  1  borrow-in; sampled on the accepting edge only.
- Diff  output  WIDTH  registered difference (A - B - Bin) mod 2^WIDTH.
- Bout  output  1  registered borrow-out; 1 when A < B + Bin (unsigned).
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse marking a new valid Diff/Bout.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - Diff, Bout, busy, done, the internal shift registers, the borrow flop and the bit counter are all 0.
  - Reset mid-operation aborts the operation with no result and no done pulse.
- Internal state:
  - a_sr, b_sr, d_sr: WIDTH-bit shift registers.
  - br: borrow flop.
  - cnt: bit counter, wide enough to hold WIDTH.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at edge E0: latch a_sr=A, b_sr=B, br=Bin, cnt=0, d_sr=0; go to SHIFT with busy=1.
  - If start=0: stay in IDLE.
- SHIFT (edges E1..E_WIDTH), on each edge with a=a_sr[0], b=b_sr[0]:
  - d = a ^ b ^ br.
  - br <= (~a & b) | (~(a ^ b) & br).
  - d_sr <= {d, d_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one.
  - cnt increments.
  - At edge E_WIDTH (the final bit):
    - Diff <= final d_sr, including that edge's bit.
    - Bout <= final borrow.
    - done <= 1, busy <= 0; go to DONE.
- DONE:
  - Lasts one cycle; at edge E_WIDTH+1, done <= 0 and the state returns to IDLE.
- Latency and throughput:
  - done is high in the cycle immediately after edge E_WIDTH.
  - Result latency is WIDTH clocks from the accepting edge.
  - Minimum issue interval is WIDTH+2 clocks.
- Start handling:
  - start is ignored in SHIFT and DONE; there is no queuing.
  - A start held high continuously re-launches on each IDLE visit.
- Operand stability: A/B/Bin changes after E0 have no effect on an operation in flight.
- Result holding:
  - Diff/Bout hold the last result indefinitely.
  - They are not cleared by a new start; they change only at the completing edge.
- Reset/start collision: reset dominates start asserted in the same cycle as reset release until rst_n is sampled high. The first legal accept is the first rising edge with rst_n=1.
- Equivalence: Diff and Bout must equal {Bout, Diff} = {1'b0, A} - {1'b0, B} - Bin in (WIDTH+1)-bit two's complement, with Bout taken as the sign bit.

Test Plan (WIDTH=4 unless noted):
1. Reset mid-operation and async reset:
   - Stimulus: reset; A=1010, B=0101, Bin=0, start for 1 cycle; after 2 clocks drop rst_n between clock edges.
   - Required response: immediately all outputs 0 and state IDLE; no done pulse ever. Repeat the operation without reset -> done 4 clocks after accept, Diff=0101, Bout=0, busy high exactly 4 cycles.
2. Borrow and Bin boundaries:
   - A=1000, B=1101, Bin=1 -> Diff=1010, Bout=1.
   - A=0000, B=1111, Bin=1 -> Diff=0000, Bout=1 (maximum borrow).
   - A=1111, B=1111, Bin=0 -> Diff=0000, Bout=0.
3. Ignored start and operand stability:
   - Stimulus: A=1101, B=0111, Bin=0 launched; pulse start again and change A/B while busy.
   - Required response: second start ignored; Diff=0110, Bout=0; exactly one done pulse.
4. Back-to-back requests with start held high:
   - First operation A=1010, B=1100 -> Diff=1110, Bout=1.
   - Relaunch at WIDTH+2 spacing with A=0011, B=0001 -> Diff=0010, Bout=0.
   - Diff holds 1110 until the second completing edge.
5. WIDTH=8 random regression:
   - Stimulus: 1000 random A/B/Bin.
   - Required response: compare against the 9-bit reference subtraction; latency is exactly 8 clocks from accept to done in every case.
